student_piso16: RTL

Parallel-in/serial-out transmitter for the 16-bit datapath. It accepts one word through a valid/ready load handshake and emits it one bit per accepted beat on a valid/ready serial port, LSB first, with a last-bit marker. It is the expanding counterpart of the word-to-bit reduction gates: a receiver or bit-serial consumer sits on the serial side. The block also latches a word-nonzero flag (OR of all loaded bits) so consumers can skip all-zero words.

---
 rtl/student_piso16.sv | 88 ++++++++
 1 files changed

// File: rtl/student_piso16.sv
// Parallel-in/serial-out transmitter: one word per load handshake, emitted LSB first
// on a valid/ready serial port with a last-bit marker and a latched nonzero flag.
module student_piso16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             word_nonzero,
  output logic             busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [3:0] LAST = 4'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [3:0]       cnt;
  logic             nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Outputs decode only registered state, so sout_ready/load_valid never reach them.
  always_comb begin
    state_nx     = state;
    load_ready   = 1'b0;
    sout_valid   = 1'b0;
    busy         = 1'b0;
    sout         = 1'b0;
    sout_last    = 1'b0;
    word_nonzero = nz;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
        sout       = sreg[0];
        sout_last  = (cnt == LAST);
        if (sout_ready && cnt == LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
      nz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            sreg <= load_data;
            cnt  <= '0;
            nz   <= |load_data;
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            if (cnt == LAST) begin
              sreg <= '0;
              cnt  <= '0;
            end else begin
              sreg <= {1'b0, sreg[WIDTH-1:1]};
              cnt  <= cnt + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
